// File: rtl/instream_arbiter_pkg.sv
// Shared constants for the instream_arbiter block: FSM state encodings and
// the width of the optional per-requester word counters.
package instream_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int W_STAT = 32;

endpackage

// File: rtl/instream_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first active request strictly
// after ptr, wrapping around to the lowest index.
module instream_arbiter_rr_pick
  import instream_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [LOG_NUM_REQ-1:0] ptr,
  output logic                   valid,
  output logic [LOG_NUM_REQ-1:0] idx
);

  // First pass finds the lowest request overall (the wrap case); the second
  // overrides it with the lowest request above ptr when one exists.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = LOG_NUM_REQ'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) idx = LOG_NUM_REQ'(i);
    end
  end

endmodule

// File: rtl/instream_arbiter.sv
// Round-robin arbiter sharing one Q/DEQ/EMPTY stream among NUM_REQ consumers,
// grant locked per burst. Define INSTREAM_ARBITER_STAT_EN for per-requester word counters.
module instream_arbiter
  import instream_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int W_D         = 32,
  parameter int W_LEN       = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*W_LEN-1:0] REQ_LEN,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [LOG_NUM_REQ-1:0]   CUR_ID,
  output logic                     BUSY,
  output logic [NUM_REQ-1:0]       DONE,
  input  logic [W_D-1:0]           S_Q,
  input  logic                     S_EMPTY,
  output logic                     S_DEQ,
  output logic [W_D-1:0]           C_Q,
  output logic [NUM_REQ-1:0]       C_EMPTY,
  input  logic [NUM_REQ-1:0]       C_DEQ
`ifdef INSTREAM_ARBITER_STAT_EN
  ,
  input  logic                      STAT_CLR,
  output logic [NUM_REQ*W_STAT-1:0] STAT_WORDS
`endif
);

  logic [1:0]             state;
  logic [LOG_NUM_REQ-1:0] ptr;
  logic [LOG_NUM_REQ-1:0] cur_id;
  logic [W_LEN-1:0]       remaining;
  logic                   pick_valid;
  logic [LOG_NUM_REQ-1:0] pick_idx;
  logic [W_LEN-1:0]       pick_len;
  logic                   xfer;

  instream_arbiter_rr_pick #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_rr_pick (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_len = REQ_LEN[pick_idx*W_LEN +: W_LEN];
  assign xfer     = (state == ST_XFER);
  assign BUSY     = xfer;
  assign CUR_ID   = cur_id;
  assign C_Q      = S_Q;

  // Grant and the stream steering derive from the registered state, so the
  // cycle after the last dequeue already shows all consumers empty.
  always_comb begin
    GNT     = '0;
    DONE    = '0;
    C_EMPTY = '1;
    S_DEQ   = 1'b0;
    if (xfer) begin
      GNT[cur_id]     = 1'b1;
      C_EMPTY[cur_id] = S_EMPTY;
      S_DEQ           = C_DEQ[cur_id] & ~S_EMPTY;
    end
    if (state == ST_FIN) DONE[cur_id] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      ptr       <= LOG_NUM_REQ'(NUM_REQ - 1);
      cur_id    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur_id    <= pick_idx;
            remaining <= pick_len;
            state     <= (pick_len == '0) ? ST_FIN : ST_XFER;
          end
        end
        ST_XFER: begin
          if (S_DEQ) begin
            remaining <= remaining - 1'b1;
            if (remaining == W_LEN'(1)) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          ptr   <= cur_id;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTREAM_ARBITER_STAT_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [W_STAT-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt <= '0;
      end else if (STAT_CLR) begin
        cnt <= '0;
      end else if (S_DEQ && (cur_id == LOG_NUM_REQ'(g)) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign STAT_WORDS[g*W_STAT +: W_STAT] = cnt;
  end
`endif

endmodule

// File: tb/tb_instream_arbiter.sv
// Testbench for instream_arbiter: table vectors, directed burst sequences and a
// randomized run against a behavioural model. Honours INSTREAM_ARBITER_STAT_EN.
module tb_instream_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int LOG_NUM_REQ = 2;
  localparam int W_D         = 32;
  localparam int W_LEN       = 16;

  logic                     CLK = 1'b0;
  logic                     RST_N = 1'b0;
  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ*W_LEN-1:0] REQ_LEN;
  logic [NUM_REQ-1:0]       GNT;
  logic [LOG_NUM_REQ-1:0]   CUR_ID;
  logic                     BUSY;
  logic [NUM_REQ-1:0]       DONE;
  logic [W_D-1:0]           S_Q;
  logic                     S_EMPTY;
  logic                     S_DEQ;
  logic [W_D-1:0]           C_Q;
  logic [NUM_REQ-1:0]       C_EMPTY;
  logic [NUM_REQ-1:0]       C_DEQ;
`ifdef INSTREAM_ARBITER_STAT_EN
  logic                     STAT_CLR;
  logic [NUM_REQ*32-1:0]    STAT_WORDS;
`endif

  instream_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ),
    .W_D         (W_D),
    .W_LEN       (W_LEN)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .REQ_LEN    (REQ_LEN),
    .GNT        (GNT),
    .CUR_ID     (CUR_ID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .S_Q        (S_Q),
    .S_EMPTY    (S_EMPTY),
    .S_DEQ      (S_DEQ),
    .C_Q        (C_Q),
    .C_EMPTY    (C_EMPTY),
    .C_DEQ      (C_DEQ)
`ifdef INSTREAM_ARBITER_STAT_EN
    ,
    .STAT_CLR   (STAT_CLR),
    .STAT_WORDS (STAT_WORDS)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] req;
    int         len;
    int         exp_id;
    int         exp_words;
  } vec_t;

  vec_t vecs[6];

  // behavioural model state: phase 0 idle, 1 transferring, 2 finishing
  int          m_phase;
  int          m_ptr;
  int          m_id;
  int          m_rem;
  logic [31:0] m_stat[NUM_REQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_len_all(input int l);
    for (int i = 0; i < NUM_REQ; i++) REQ_LEN[i*W_LEN +: W_LEN] = W_LEN'(l);
  endtask

  task automatic do_reset();
    RST_N   = 1'b0;
    REQ     = '0;
    REQ_LEN = '0;
    C_DEQ   = '0;
    S_EMPTY = 1'b1;
    S_Q     = '0;
`ifdef INSTREAM_ARBITER_STAT_EN
    STAT_CLR = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          deq;
    int          rem;
    int          cnt;
    logic [3:0]  done_v;
    logic        cd;
    logic        e;
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic [3:0]  e_cempty;
    logic        e_sdeq;
    int          p;
    int          b;
    int          len;
    int          j;
    bit          found;

    vecs[0] = '{4'b0001, 8, 0, 8};
    vecs[1] = '{4'b1111, 3, 0, 3};
    vecs[2] = '{4'b0100, 1, 2, 1};
    vecs[3] = '{4'b1000, 0, 3, 0};
    vecs[4] = '{4'b1010, 5, 1, 5};
    vecs[5] = '{4'b1100, 2, 2, 2};

    // reset state
    do_reset();
    chk("rst_gnt", 64'(GNT), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_cur_id", 64'(CUR_ID), 64'(0));
    chk("rst_sdeq", 64'(S_DEQ), 64'(0));
    chk("rst_cempty", 64'(C_EMPTY), 64'hF);
`ifdef INSTREAM_ARBITER_STAT_EN
    for (int i = 0; i < NUM_REQ; i++) chk("rst_stat", 64'(STAT_WORDS[i*32 +: 32]), 64'(0));
`endif

    // table vectors, each from reset so requester 0 leads the rotation
    for (int v = 0; v < 6; v++) begin
      do_reset();
      REQ = vecs[v].req;
      set_len_all(vecs[v].len);
      C_DEQ = '1;
      S_EMPTY = 1'b0;
      step();
      chk("tbl_first_gnt", 64'(GNT), 64'((vecs[v].len > 0) ? oh(vecs[v].exp_id) : 4'b0));
      deq = 0;
      done_v = '0;
      for (int c = 0; c < 100; c++) begin
        if (DONE != '0) begin
          done_v = DONE;
          break;
        end
        deq += int'(S_DEQ);
        step();
      end
      REQ = '0;
      chk("tbl_words", 64'(deq), 64'(vecs[v].exp_words));
      chk("tbl_done", 64'(done_v), 64'(oh(vecs[v].exp_id)));
      step();
      chk("tbl_done_clear", 64'(DONE), 64'(0));
      chk("tbl_busy_low", 64'(BUSY), 64'(0));
    end

    // all requesting, LEN=2: order 0,1,2,3,0 with 2 gap cycles between grants
    do_reset();
    REQ = '1;
    set_len_all(2);
    C_DEQ = '1;
    S_EMPTY = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      p = (c - 1) % 4;
      b = ((c - 1) / 4) % 4;
      chk("rr_gnt", 64'(GNT), 64'((p < 2) ? oh(b) : 4'b0));
      chk("rr_done", 64'(DONE), 64'((p == 2) ? oh(b) : 4'b0));
    end
    REQ = '0;
    step();

    // requester 1 granted; requester 2 dequeue must be ignored; REQ dropped mid-burst
    REQ = 4'b0010;
    set_len_all(4);
    C_DEQ = 4'b0100;
    step();
    chk("ng_gnt_start", 64'(GNT), 64'(4'b0010));
    REQ = '0;
    rem = 4;
    for (int c = 0; c < 60 && rem > 0; c++) begin
      cd = 1'($urandom_range(0, 1));
      C_DEQ[1] = cd;
      #1;
      chk("ng_sdeq", 64'(S_DEQ), 64'(cd));
      chk("ng_cempty2", 64'(C_EMPTY[2]), 64'(1));
      chk("ng_gnt", 64'(GNT), 64'(4'b0010));
      if (cd) rem--;
      step();
    end
    chk("ng_done", 64'(DONE), 64'(4'b0010));
    C_DEQ = '0;
    step();

    // stalling upstream: S_EMPTY toggles, 5 real dequeues complete the burst
    REQ = 4'b0001;
    set_len_all(5);
    C_DEQ = 4'b0001;
    S_EMPTY = 1'b1;
    step();
    REQ = '0;
    cnt = 0;
    e = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (DONE != '0) break;
      e = ~e;
      S_EMPTY = e;
      #1;
      chk("em_sdeq", 64'(S_DEQ), 64'(!e));
      cnt += int'(S_DEQ);
      step();
    end
    chk("em_count", 64'(cnt), 64'(5));
    chk("em_done", 64'(DONE), 64'(4'b0001));
    S_EMPTY = 1'b0;
    #1;
    chk("em_no_overread", 64'(S_DEQ), 64'(0));
    chk("em_cempty_fin", 64'(C_EMPTY), 64'hF);
    step();

    // zero-length request: no grant, DONE pulse, pointer moves to 3
    REQ = 4'b0010;
    set_len_all(1);
    C_DEQ = 4'b0010;
    step();
    REQ = '0;
    step();
    chk("z_pre_done", 64'(DONE), 64'(4'b0010));
    step();
    REQ = 4'b1000;
    set_len_all(0);
    step();
    chk("z_gnt", 64'(GNT), 64'(0));
    chk("z_done", 64'(DONE), 64'(4'b1000));
    chk("z_busy", 64'(BUSY), 64'(0));
    REQ = 4'b0101;
    set_len_all(1);
    step();
    chk("z_idle_gnt", 64'(GNT), 64'(0));
    step();
    chk("z_ptr_adv", 64'(GNT), 64'(4'b0001));
    REQ = '0;
    C_DEQ = 4'b0001;
    step();
    step();

    // asynchronous reset during a LEN=10 burst after 4 words
    REQ = 4'b0100;
    set_len_all(10);
    C_DEQ = '1;
    S_EMPTY = 1'b0;
    step();
    chk("ar_gnt", 64'(GNT), 64'(4'b0100));
    REQ = '0;
    repeat (4) step();
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_gnt_off", 64'(GNT), 64'(0));
    chk("ar_busy_off", 64'(BUSY), 64'(0));
    chk("ar_done_off", 64'(DONE), 64'(0));
    chk("ar_sdeq_off", 64'(S_DEQ), 64'(0));
`ifdef INSTREAM_ARBITER_STAT_EN
    for (int i = 0; i < NUM_REQ; i++) chk("ar_stat", 64'(STAT_WORDS[i*32 +: 32]), 64'(0));
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    REQ = 4'b0101;
    set_len_all(1);
    step();
    chk("ar_first_winner", 64'(GNT), 64'(4'b0001));
    REQ = '0;
    step();
    step();

    // randomized run against the behavioural model
    do_reset();
    m_phase = 0;
    m_ptr   = NUM_REQ - 1;
    m_id    = 0;
    m_rem   = 0;
    for (int i = 0; i < NUM_REQ; i++) m_stat[i] = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        REQ[i] = ($urandom_range(0, 2) == 0);
        REQ_LEN[i*W_LEN +: W_LEN] = W_LEN'($urandom_range(0, 4));
        C_DEQ[i] = 1'($urandom_range(0, 1));
      end
      S_EMPTY = ($urandom_range(0, 2) == 0);
      S_Q = $urandom;
`ifdef INSTREAM_ARBITER_STAT_EN
      STAT_CLR = ($urandom_range(0, 99) == 0);
`endif
      @(negedge CLK);
      e_gnt    = (m_phase == 1) ? oh(m_id) : 4'b0;
      e_done   = (m_phase == 2) ? oh(m_id) : 4'b0;
      e_sdeq   = (m_phase == 1) && C_DEQ[m_id] && !S_EMPTY;
      e_cempty = 4'hF;
      if (m_phase == 1) e_cempty[m_id] = S_EMPTY;
      chk("rnd_gnt", 64'(GNT), 64'(e_gnt));
      chk("rnd_done", 64'(DONE), 64'(e_done));
      chk("rnd_busy", 64'(BUSY), 64'(m_phase == 1));
      chk("rnd_cur_id", 64'(CUR_ID), 64'(m_id));
      chk("rnd_sdeq", 64'(S_DEQ), 64'(e_sdeq));
      chk("rnd_cempty", 64'(C_EMPTY), 64'(e_cempty));
      chk("rnd_cq", 64'(C_Q), 64'(S_Q));
`ifdef INSTREAM_ARBITER_STAT_EN
      if (STAT_CLR) begin
        for (int i = 0; i < NUM_REQ; i++) m_stat[i] = '0;
      end else if (e_sdeq && m_stat[m_id] != 32'hFFFFFFFF) begin
        m_stat[m_id] = m_stat[m_id] + 1;
      end
`endif
      if (m_phase == 0) begin
        found = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (m_ptr + k) % NUM_REQ;
          if (!found && REQ[j]) begin
            found = 1;
            m_id = j;
            len = int'(REQ_LEN[j*W_LEN +: W_LEN]);
            if (len == 0) m_phase = 2;
            else begin
              m_rem = len;
              m_phase = 1;
            end
          end
        end
      end else if (m_phase == 1) begin
        if (e_sdeq) begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end else begin
        m_ptr = m_id;
        m_phase = 0;
      end
      @(posedge CLK);
      #1;
    end
`ifdef INSTREAM_ARBITER_STAT_EN
    STAT_CLR = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) chk("rnd_stat", 64'(STAT_WORDS[i*32 +: 32]), 64'(m_stat[i]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
